rtc_bus_sequencer: RTL and testbench
====================================

RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 8, width of the multiplexed address/data bus.
- CW, 4, width of the burst-count input.
- T_ADDR, 7, cycles that cs/wr are held low in the address phase (>=1).
- T_GAP, 6, idle cycles between address and data phases (>=1).
- T_DATA, 7, cycles that the data strobe is held low (>=2).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous and active-high.
- start  in  1  request a transaction; sampled only while busy=0.
- in_escribir_leer  in  1  1 = write, 0 = read; latched at start.
- in_direccion  in  DW  first RTC register address; latched at start.
- in_cantidad  in  CW  number of transfers; latched at start.
- in_dato  in  DW  write data; sampled on entry to each write data phase.
- bus_in  in  DW  value read back from the bus pads.
- bus_out  out  DW  value driven onto the bus.
- bus_oe  out  1  pad output enable; 1 = drive bus_out.
- reg_a_d, reg_cs, reg_wr, reg_rd  out  1 each  RTC strobes, active-low.
- busy  out  1  transaction in progress.
- data_ack  out  1  one-cycle pulse; current write word consumed.
- rd_valid  out  1  one-cycle pulse; rd_dato holds a new read word.
- rd_dato  out  DW  captured read data.
- flag_done  out  1  one-cycle pulse; transaction complete.

Function
REQ-003 States: IDLE, ADDR_SETUP (1 cycle), ADDR_STROBE (T_ADDR), ADDR_HOLD (1), GAP (T_GAP), DATA_STROBE (T_DATA), DATA_HOLD (1), DONE (1); one down-counter times the multi-cycle states.
REQ-004 All outputs SHALL be driven from registered state, counter and data registers only, with no combinational path from any input.
REQ-005 IDLE with start=1 -> ADDR_SETUP on the next edge: latch address, direction and count (cnt); busy=1 from that cycle until DONE inclusive.
REQ-006 start with in_cantidad=0 -> DONE directly (flag_done after 1 cycle), with no strobe activity.
REQ-007 Per-state outputs:
- ADDR_SETUP: a_d=0, others 1.
- ADDR_STROBE: a_d=0, cs=0, wr=0; bus_oe=1; bus_out=current address.
- ADDR_HOLD: a_d=0, cs=1, wr=1; bus_oe=1; bus_out=address.
- GAP: all strobes 1, bus_oe=0.
- DATA_STROBE: a_d=1, cs=0; write: wr=0, bus_oe=1, bus_out=data word; read: rd=0, bus_oe=0.
- DATA_HOLD: strobes 1; write: bus_oe=1, bus_out held; read: bus_oe=0.
REQ-008 The write data register SHALL load in_dato on the GAP->DATA_STROBE edge.
REQ-009 Read: rd_dato SHALL capture bus_in on the DATA_STROBE->DATA_HOLD edge; rd_valid=1 during DATA_HOLD.
REQ-010 Write: data_ack=1 during DATA_HOLD; the host SHALL update in_dato before the next GAP ends.
REQ-011 DATA_HOLD exit: cnt-1 > 0 -> ADDR_SETUP with address+1 (mod 2^DW, wraps all-ones to 0) and cnt decremented; otherwise -> DONE.
REQ-012 DONE: flag_done=1, then IDLE on the next edge. start asserted in DONE or while busy=1 SHALL be ignored.
REQ-013 bus_oe SHALL never be 1 in any cycle where reg_rd=0.

Reset
REQ-014 reset=1 SHALL immediately force: state IDLE; a_d, cs, wr, rd =1; bus_oe=0; bus_out=0; rd_dato=0; busy, data_ack, rd_valid, flag_done =0; counters=0. This applies mid-transaction with no completion pulse, and the transaction is not resumed.

Verification
REQ-015 Defaults; single write, addr 0x21, data 0x45, start at edge 0 -> a_d low cycles 1-9; cs/wr low cycles 2-8 with bus_out=0x21; cs/wr low cycles 16-22 with bus_out=0x45; data_ack at cycle 23; flag_done at cycle 24 only; busy cycles 1-24.
REQ-016 Single read, addr 0x0C, bus_in=0x5A during cycles 16-22 -> rd low cycles 16-22, bus_oe=0 throughout data phase; rd_valid at cycle 23 with rd_dato=0x5A.
REQ-017 Write burst, in_cantidad=3, addr 0xFE -> address phases drive 0xFE, 0xFF, 0x00; three data_ack pulses 23 cycles apart; one flag_done.
REQ-018 reset pulse at cycle 18 of a write -> strobes 1 and bus_oe=0 in the same cycle; no flag_done; the next start completes normally.
REQ-019 in_cantidad=0 -> flag_done one cycle after ADDR entry would occur, with strobes never low. start while busy -> no effect on timing.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for an RTC: runs address, gap and
// data phases per transfer, with burst support via an auto-incrementing address.
module rtc_bus_sequencer #(
  parameter int DW     = 8,
  parameter int CW     = 4,
  parameter int T_ADDR = 7,
  parameter int T_GAP  = 6,
  parameter int T_DATA = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_escribir_leer,
  input  logic [DW-1:0] in_direccion,
  input  logic [CW-1:0] in_cantidad,
  input  logic [DW-1:0] in_dato,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          reg_a_d,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic          reg_rd,
  output logic          busy,
  output logic          data_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_dato,
  output logic          flag_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, GAP, DATA_STROBE, DATA_HOLD, DONE
  } state_t;

  localparam int TMAX = (T_ADDR > T_GAP) ? ((T_ADDR > T_DATA) ? T_ADDR : T_DATA)
                                         : ((T_GAP > T_DATA) ? T_GAP : T_DATA);
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic          is_write;

  // NOTE: async reset in the sensitivity list and <= for every register, so
  // all state updates see pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (start) next_state = (in_cantidad == '0) ? DONE : ADDR_SETUP;
      ADDR_SETUP:  next_state = ADDR_STROBE;
      ADDR_STROBE: if (timer == '0) next_state = ADDR_HOLD;
      ADDR_HOLD:   next_state = GAP;
      GAP:         if (timer == '0) next_state = DATA_STROBE;
      DATA_STROBE: if (timer == '0) next_state = DATA_HOLD;
      DATA_HOLD:   next_state = (cnt_q > CW'(1)) ? ADDR_SETUP : DONE;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Datapath: the timer is loaded on entry to each multi-cycle state and
  // counts down to zero on its last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      is_write <= 1'b0;
      rd_dato  <= '0;
    end else begin
      if (state != next_state) begin
        case (next_state)
          ADDR_STROBE: timer <= TW'(T_ADDR - 1);
          GAP:         timer <= TW'(T_GAP - 1);
          DATA_STROBE: timer <= TW'(T_DATA - 1);
          default:     timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - TW'(1);
      end

      if (state == IDLE && start) begin
        addr_q   <= in_direccion;
        cnt_q    <= in_cantidad;
        is_write <= in_escribir_leer;
      end

      if (state == GAP && next_state == DATA_STROBE)
        wdata_q <= in_dato;

      if (state == DATA_STROBE && next_state == DATA_HOLD && !is_write)
        rd_dato <= bus_in;

      if (state == DATA_HOLD && next_state == ADDR_SETUP) begin
        addr_q <= addr_q + DW'(1);
        cnt_q  <= cnt_q - CW'(1);
      end
    end
  end

  // Moore outputs: decoded from registered state only, never from inputs.
  always_comb begin
    reg_a_d   = 1'b1;
    reg_cs    = 1'b1;
    reg_wr    = 1'b1;
    reg_rd    = 1'b1;
    bus_oe    = 1'b0;
    bus_out   = '0;
    busy      = (state != IDLE);
    data_ack  = 1'b0;
    rd_valid  = 1'b0;
    flag_done = 1'b0;
    case (state)
      ADDR_SETUP: reg_a_d = 1'b0;
      ADDR_STROBE: begin
        reg_a_d = 1'b0;
        reg_cs  = 1'b0;
        reg_wr  = 1'b0;
        bus_oe  = 1'b1;
        bus_out = addr_q;
      end
      ADDR_HOLD: begin
        reg_a_d = 1'b0;
        bus_oe  = 1'b1;
        bus_out = addr_q;
      end
      DATA_STROBE: begin
        reg_cs = 1'b0;
        if (is_write) begin
          reg_wr  = 1'b0;
          bus_oe  = 1'b1;
          bus_out = wdata_q;
        end else begin
          reg_rd = 1'b0;
        end
      end
      DATA_HOLD: begin
        if (is_write) begin
          bus_oe   = 1'b1;
          bus_out  = wdata_q;
          data_ack = 1'b1;
        end else begin
          rd_valid = 1'b1;
        end
      end
      DONE:    flag_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: per-cycle comparison of strobes, bus
// and pulses against a cycle-indexed expectation of the default timing.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_escribir_leer;
  logic [7:0] in_direccion;
  logic [3:0] in_cantidad;
  logic [7:0] in_dato;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       reg_a_d, reg_cs, reg_wr, reg_rd;
  logic       busy, data_ack, rd_valid, flag_done;
  logic [7:0] rd_dato;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .in_escribir_leer(in_escribir_leer),
    .in_direccion(in_direccion), .in_cantidad(in_cantidad), .in_dato(in_dato),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .reg_a_d(reg_a_d),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_rd(reg_rd), .busy(busy),
    .data_ack(data_ack), .rd_valid(rd_valid), .rd_dato(rd_dato), .flag_done(flag_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {a_d, cs, wr, rd, oe, busy, ack, rd_valid, done, bus (when driven)}
  function automatic logic [16:0] obs_vec();
    return {reg_a_d, reg_cs, reg_wr, reg_rd, bus_oe, busy, data_ack, rd_valid,
            flag_done, (bus_oe ? bus_out : 8'h00)};
  endfunction

  function automatic logic [7:0] word(input int k, input logic [7:0] d0, d1, d2);
    return (k == 0) ? d0 : (k == 1) ? d1 : d2;
  endfunction

  // Cycle c counts from 1 = first cycle after the edge that sampled start.
  // Each transfer spans 23 cycles: setup 1, strobe 7, hold 1, gap 6, data 7, hold 1.
  function automatic logic [16:0] exp_vec(input int c, input bit wr, input logic [7:0] a,
                                           input int n, input logic [7:0] d0, d1, d2,
                                           input int rst_at);
    logic [3:0] s  = 4'b1111;
    logic       oe = 1'b0, bz = 1'b0, ack = 1'b0, rv = 1'b0, dn = 1'b0;
    logic [7:0] b  = 8'h00;
    int k, r;
    if (rst_at != 0 && c >= rst_at) return {4'b1111, 5'b00000, 8'h00};
    if (n == 0) begin
      if (c == 1) begin bz = 1'b1; dn = 1'b1; end
    end else if (c >= 1 && c <= 23 * n) begin
      k  = (c - 1) / 23;
      r  = (c - 1) % 23;
      bz = 1'b1;
      if (r <= 8) s[3] = 1'b0;
      if (r >= 1 && r <= 7) begin s[2] = 1'b0; s[1] = 1'b0; end
      if (r >= 1 && r <= 8) begin oe = 1'b1; b = a + 8'(k); end
      if (r >= 15 && r <= 21) begin
        s[2] = 1'b0;
        if (wr) s[1] = 1'b0; else s[0] = 1'b0;
      end
      if (wr && r >= 15 && r <= 22) begin oe = 1'b1; b = word(k, d0, d1, d2); end
      if (r == 22) begin ack = wr; rv = !wr; end
    end else if (c == 23 * n + 1) begin
      bz = 1'b1; dn = 1'b1;
    end
    return {s, oe, bz, ack, rv, dn, b};
  endfunction

  task automatic run_txn(input string name, input bit wr, input logic [7:0] a, input int n,
                         input logic [7:0] d0, d1, d2, input int ncyc,
                         input bit hold_start, input int rst_at);
    int k, r;
    @(negedge clk);
    start            = 1'b1;
    in_escribir_leer = wr;
    in_direccion     = a;
    in_cantidad      = 4'(n);
    in_dato          = d0;
    bus_in           = 8'hA5;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == rst_at) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check($sformatf("%s_rst_vec", name), 32'(obs_vec()), {15'd0, 4'b1111, 5'b00000, 8'h00});
        check($sformatf("%s_rst_bus", name), 32'(bus_out), 32'h0);
        check($sformatf("%s_rst_rd_dato", name), 32'(rd_dato), 32'h0);
      end
      @(negedge clk);
      if (c == rst_at) reset = 1'b0;
      check($sformatf("%s_c%0d", name, c), 32'(obs_vec()),
            32'(exp_vec(c, wr, a, n, d0, d1, d2, rst_at)));
      k = (c - 1) / 23;
      r = (c - 1) % 23;
      if (!wr && n > 0 && c <= 23 * n && r == 22)
        check($sformatf("%s_rd_dato_w%0d", name, k), 32'(rd_dato), 32'(word(k, d0, d1, d2)));
      // Latched inputs are scrambled while busy; start is held through DONE if requested.
      start            = hold_start && c >= 5 && c <= 24;
      in_direccion     = 8'h99;
      in_cantidad      = 4'hF;
      in_escribir_leer = ~wr;
      in_dato          = word((k > 2) ? 2 : k, d0, d1, d2);
      bus_in           = (!wr && n > 0 && c <= 23 * n && r >= 15 && r <= 21)
                         ? word(k, d0, d1, d2) : 8'hA5;
    end
    start = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    start            = 1'b0;
    in_escribir_leer = 1'b0;
    in_direccion     = 8'h00;
    in_cantidad      = 4'h0;
    in_dato          = 8'h00;
    bus_in           = 8'h00;
    #12;
    check("reset_vec", 32'(obs_vec()), {15'd0, 4'b1111, 5'b00000, 8'h00});
    check("reset_bus", 32'(bus_out), 32'h0);
    check("reset_rd_dato", 32'(rd_dato), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_txn("wr1",    1'b1, 8'h21, 1, 8'h45, 8'h00, 8'h00, 30, 1'b0, 0);
    run_txn("rd1",    1'b0, 8'h0C, 1, 8'h5A, 8'h00, 8'h00, 30, 1'b0, 0);
    check("rd1_rd_dato_hold", 32'(rd_dato), 32'h5A);
    run_txn("wrb3",   1'b1, 8'hFE, 3, 8'h11, 8'h22, 8'h33, 75, 1'b0, 0);
    run_txn("wr_rst", 1'b1, 8'h30, 1, 8'h77, 8'h00, 8'h00, 30, 1'b0, 18);
    run_txn("wr_hold", 1'b1, 8'h40, 1, 8'h88, 8'h00, 8'h00, 30, 1'b1, 0);
    run_txn("zero",   1'b1, 8'h50, 0, 8'h00, 8'h00, 8'h00, 5, 1'b0, 0);
    run_txn("rdb2",   1'b0, 8'hFF, 2, 8'hC3, 8'h3C, 8'h00, 50, 1'b0, 0);
    check("rdb2_rd_dato_hold", 32'(rd_dato), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
